decode_writeback: RTL and testbench
===================================

# decode_writeback

Register-file stage of the sequential Y86-64 datapath. Decodes `icode`/`rA`/`rB` into source and destination register IDs and drives `valA`/`valB` to the execute stage combinationally. On the clock edge it commits `valE`/`valM` from execute/memory into the 15-entry 64-bit register file. It also keeps the sticky processor status and a retired-instruction counter.

## Interface
- `NREG`, 15, number of architectural registers (IDs 0x0–0xE; 0xF = RNONE)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `icode`  in  4  instruction code of current instruction
- `ifun`  in  4  function code (carried for completeness, unused by decode)
- `rA`  in  4  register specifier A
- `rB`  in  4  register specifier B
- `valE`  in  64  execute-stage result
- `valM`  in  64  memory-stage read data
- `cnd`  in  1  condition result from execute (cmovxx only)
- `wb_en`  in  1  commit strobe: current instruction retires this cycle
- `valA`  out  64  R[srcA], 0 when srcA = RNONE
- `valB`  out  64  R[srcB], 0 when srcB = RNONE
- `dstE`  out  4  decoded E destination (post-cnd)
- `dstM`  out  4  decoded M destination
- `stat`  out  3  1 = AOK, 2 = HLT, 4 = INS
- `retired`  out  64  count of committed instructions
- `dbg_reg`  in  4  debug read address
- `dbg_val`  out  64  R[dbg_reg], 0 when dbg_reg = 0xF

## Operation
- RSP = 0x4, RNONE = 0xF. Decode is purely combinational from current inputs.
- srcA:
  - rA for rrmovq/cmovxx (2), rmmovq (4), OPq (6), pushq (A).
  - RSP for ret (9), popq (B).
  - Otherwise RNONE.
- srcB:
  - rB for rmmovq, mrmovq (5), OPq.
  - RSP for call (8), ret, pushq, popq.
  - Otherwise RNONE.
- dstE:
  - cmovxx: rB if `cnd`, else RNONE; ifun 0 (rrmovq) relies on execute driving `cnd`=1.
  - rB for irmovq (3), OPq.
  - RSP for call, ret, pushq, popq.
  - Otherwise RNONE.
- dstM: rA for mrmovq, popq; otherwise RNONE.
- Valid icodes: 0x0–0xB. 0x0 = halt.
- Commit occurs on a rising edge with `rst_n`=1, `wb_en`=1 and `stat`=AOK:
  - icode valid and ≠ 0: if dstE ≠ RNONE, R[dstE] ← valE; if dstM ≠ RNONE, R[dstM] ← valM.
  - dstE = dstM (popq %rsp): valM wins.
  - icode 0: no register write; `stat` ← HLT.
  - icode > 0xB: no register write; `stat` ← INS.
  - In every case `retired` increments by 1, including the halt/INS instruction itself.
- When `stat` ≠ AOK, all register writes and counter increments are blocked. The status is sticky until reset.
- `wb_en`=0 means no state change of any kind.
- `valA`/`valB`/`dbg_val` return the pre-edge register value, with no internal forwarding. A read of a register being written in the same cycle returns the old value.
- `retired` wraps modulo 2^64.

## Timing
- Reset (rst_n=0 at rising edge) sets R[0..14] = 0, `stat` = 1 (AOK), `retired` = 0. Reset dominates `wb_en`.
- Reset asserted mid-program clears everything on that edge; no partial commit.
- Read path: `valA`, `valB`, `dstE`, `dstM`, `dbg_val` are combinational, with zero-cycle latency from inputs/state.
- Write path: one-cycle latency; a value committed at edge N is visible on `valA`/`valB`/`dbg_val` after edge N.
- `stat` and `retired` update on the same edge as the commit.
- After reset: `valA` = `valB` = 0 for any source.

## Test plan
- Reset, then irmovq (icode 3, rB=2, valE=0x1234, wb_en=1) -> after the edge, dbg_reg=2 gives 0x1234; `retired`=1; `stat`=1.
- OPq (icode 6, rA=2, rB=3) with R2=5, R3=7 -> combinationally valA=5, valB=7, dstE=3. Commit valE=12 -> R3=12.
- popq %rsp (icode B, rA=4) with valE=0x108, valM=0xDEAD -> R4=0xDEAD (valM wins). Same-cycle valA still shows the old RSP.
- cmovxx (icode 2, rA=1, rB=5, cnd=0, valE=9) -> dstE=0xF, R5 unchanged. Repeat with cnd=1 -> R5=9.
- Halt (icode 0, wb_en=1) -> `stat`=2, `retired`+1. A subsequent irmovq to R1 has no effect and `retired` is frozen. rst_n=0 restores `stat`=1, all registers 0.
- icode 0xC, wb_en=1 -> `stat`=4, no writes. An mrmovq issued with wb_en=0 -> no state change.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register-ID decode, 15x64 register file,
// sticky processor status and retired-instruction counter.
module decode_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        cnd,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [2:0]  stat,
    output logic [63:0] retired,
    input  logic [3:0]  dbg_reg,
    output logic [63:0] dbg_val
);

    localparam int unsigned NREG  = 15;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned RIDW  = 4;
    localparam int unsigned STATW = 3;

    localparam logic [RIDW-1:0] RSP   = 4'h4;
    localparam logic [RIDW-1:0] RNONE = 4'hF;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [STATW-1:0] S_AOK = 3'd1;
    localparam logic [STATW-1:0] S_HLT = 3'd2;
    localparam logic [STATW-1:0] S_INS = 3'd4;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [STATW-1:0] stat_q, stat_d;
    logic [XLEN-1:0]  retired_q, retired_d;
    logic [RIDW-1:0]  src_a_c, src_b_c;
    logic             wr_e_c, wr_m_c;

    // ifun is carried through but has no effect on decode
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    function automatic logic [XLEN-1:0] rf_read(input logic [RIDW-1:0] id);
        rf_read = '0;
        for (int i = 0; i < NREG; i++) begin
            if (id == RIDW'(i)) rf_read = regs_q[i];
        end
    endfunction

    // Register-ID decode
    always_comb begin
        src_a_c = RNONE;
        src_b_c = RNONE;
        dstE    = RNONE;
        dstM    = RNONE;
        case (icode)
            I_RRMOVQ: begin
                src_a_c = rA;
                dstE    = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                src_a_c = rA;
                src_b_c = rB;
            end
            I_MRMOVQ: begin
                src_b_c = rB;
                dstM    = rA;
            end
            I_OPQ: begin
                src_a_c = rA;
                src_b_c = rB;
                dstE    = rB;
            end
            I_CALL: begin
                src_b_c = RSP;
                dstE    = RSP;
            end
            I_RET: begin
                src_a_c = RSP;
                src_b_c = RSP;
                dstE    = RSP;
            end
            I_PUSHQ: begin
                src_a_c = rA;
                src_b_c = RSP;
                dstE    = RSP;
            end
            I_POPQ: begin
                src_a_c = RSP;
                src_b_c = RSP;
                dstE    = RSP;
                dstM    = rA;
            end
            default: ;
        endcase
    end

    assign valA    = rf_read(src_a_c);
    assign valB    = rf_read(src_b_c);
    assign dbg_val = rf_read(dbg_reg);

    // Commit decision: halt/invalid retire without touching the register file
    always_comb begin
        stat_d    = stat_q;
        retired_d = retired_q;
        wr_e_c    = 1'b0;
        wr_m_c    = 1'b0;
        if (wb_en && stat_q == S_AOK) begin
            retired_d = retired_q + XLEN'(1);
            if (icode == I_HALT) begin
                stat_d = S_HLT;
            end else if (icode > I_POPQ) begin
                stat_d = S_INS;
            end else begin
                wr_e_c = (dstE != RNONE);
                wr_m_c = (dstM != RNONE);
            end
        end
    end

    // State update; the M write is issued last so it wins when dstE == dstM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            stat_q    <= S_AOK;
            retired_q <= '0;
        end else begin
            stat_q    <= stat_d;
            retired_q <= retired_d;
            for (int i = 0; i < NREG; i++) begin
                if (wr_e_c && dstE == RIDW'(i)) regs_q[i] <= valE;
                if (wr_m_c && dstM == RIDW'(i)) regs_q[i] <= valM;
            end
        end
    end

    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: decode, commit ordering, status and counter.
module tb_decode_writeback;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode, ifun, rA, rB, dbg_reg;
    logic [63:0] valE, valM;
    logic        cnd, wb_en;
    logic [63:0] valA, valB, retired, dbg_val;
    logic [3:0]  dstE, dstM;
    logic [2:0]  stat;

    int unsigned n_checks;
    int unsigned n_pass;

    decode_writeback dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icode   (icode),
        .ifun    (ifun),
        .rA      (rA),
        .rB      (rB),
        .valE    (valE),
        .valM    (valM),
        .cnd     (cnd),
        .wb_en   (wb_en),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .dstM    (dstM),
        .stat    (stat),
        .retired (retired),
        .dbg_reg (dbg_reg),
        .dbg_val (dbg_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] e, input logic [63:0] m, input logic c,
                         input logic en);
        icode = ic; rA = ra; rB = rb; valE = e; valM = m; cnd = c; wb_en = en;
        #1;
    endtask

    task automatic peek(input logic [3:0] r, input string tag, input logic [63:0] exp);
        dbg_reg = r;
        #1;
        check(tag, dbg_val, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; ifun = 4'h0; dbg_reg = 4'hF;
        issue(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_stat", 64'(stat), 64'd1);
        check("rst_retired", retired, 64'd0);
        issue(4'h6, 4'h2, 4'h3, 64'h0, 64'h0, 1'b0, 1'b0);
        check("rst_valA", valA, 64'd0);
        check("rst_valB", valB, 64'd0);
        peek(4'hF, "dbg_rnone", 64'd0);

        // irmovq 0x1234 -> R2
        issue(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 1'b0, 1'b1);
        check("irmov_dstE", 64'(dstE), 64'h2);
        check("irmov_dstM", 64'(dstM), 64'hF);
        tick();
        wb_en = 1'b0;
        peek(4'h2, "irmov_R2", 64'h1234);
        check("irmov_retired", retired, 64'd1);
        check("irmov_stat", 64'(stat), 64'd1);

        // R2=5, R3=7, then OPq R2,R3
        issue(4'h3, 4'hF, 4'h2, 64'd5, 64'h0, 1'b0, 1'b1); tick();
        issue(4'h3, 4'hF, 4'h3, 64'd7, 64'h0, 1'b0, 1'b1); tick();
        issue(4'h6, 4'h2, 4'h3, 64'd12, 64'h0, 1'b0, 1'b1);
        check("opq_valA", valA, 64'd5);
        check("opq_valB", valB, 64'd7);
        check("opq_dstE", 64'(dstE), 64'h3);
        tick();
        wb_en = 1'b0;
        peek(4'h3, "opq_R3", 64'd12);
        check("opq_retired", retired, 64'd4);

        // RSP=0x100, then popq %rsp: valM must win
        issue(4'h3, 4'hF, 4'h4, 64'h100, 64'h0, 1'b0, 1'b1); tick();
        issue(4'hB, 4'h4, 4'hF, 64'h108, 64'hDEAD, 1'b0, 1'b1);
        check("popq_valA_old", valA, 64'h100);
        check("popq_dstE", 64'(dstE), 64'h4);
        check("popq_dstM", 64'(dstM), 64'h4);
        peek(4'h4, "popq_dbg_old", 64'h100);
        tick();
        wb_en = 1'b0;
        peek(4'h4, "popq_R4", 64'hDEAD);
        check("popq_retired", retired, 64'd6);

        // call reads RSP on B only
        issue(4'h8, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
        check("call_valA", valA, 64'd0);
        check("call_valB", valB, 64'hDEAD);

        // cmovxx not taken, then taken
        issue(4'h2, 4'h1, 4'h5, 64'd9, 64'h0, 1'b0, 1'b1);
        check("cmov_nt_dstE", 64'(dstE), 64'hF);
        tick();
        wb_en = 1'b0;
        peek(4'h5, "cmov_nt_R5", 64'd0);
        issue(4'h2, 4'h1, 4'h5, 64'd9, 64'h0, 1'b1, 1'b1);
        check("cmov_t_dstE", 64'(dstE), 64'h5);
        tick();
        wb_en = 1'b0;
        peek(4'h5, "cmov_t_R5", 64'd9);
        check("cmov_retired", retired, 64'd8);

        // mrmovq with wb_en=0 changes nothing
        issue(4'h5, 4'h6, 4'h2, 64'h0, 64'h77, 1'b0, 1'b0);
        check("mrmov_dstM", 64'(dstM), 64'h6);
        check("mrmov_valB", valB, 64'd5);
        tick();
        peek(4'h6, "nowb_R6", 64'd0);
        check("nowb_retired", retired, 64'd8);

        // halt, then a blocked irmovq
        issue(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        check("halt_stat", 64'(stat), 64'd2);
        check("halt_retired", retired, 64'd9);
        issue(4'h3, 4'hF, 4'h1, 64'h55, 64'h0, 1'b0, 1'b1);
        tick();
        wb_en = 1'b0;
        peek(4'h1, "halt_R1", 64'd0);
        check("halt_frozen", retired, 64'd9);
        check("halt_sticky", 64'(stat), 64'd2);

        // reset dominates a pending commit
        rst_n = 1'b0;
        issue(4'h3, 4'hF, 4'h1, 64'h66, 64'h0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        wb_en = 1'b0;
        check("rst2_stat", 64'(stat), 64'd1);
        check("rst2_retired", retired, 64'd0);
        peek(4'h1, "rst2_R1", 64'd0);
        peek(4'h3, "rst2_R3", 64'd0);
        peek(4'h4, "rst2_R4", 64'd0);

        // invalid icode
        issue(4'hC, 4'hF, 4'h2, 64'h99, 64'h0, 1'b0, 1'b1);
        tick();
        wb_en = 1'b0;
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_retired", retired, 64'd1);
        peek(4'h2, "ins_R2", 64'd0);
        issue(4'h3, 4'hF, 4'h2, 64'h42, 64'h0, 1'b0, 1'b1);
        tick();
        wb_en = 1'b0;
        peek(4'h2, "ins_blocked_R2", 64'd0);
        check("ins_frozen", retired, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
